seq_decoder_3to8: RTL and testbench

Registered 3-to-8 decoder with a valid/ready input handshake and timed one-hot output pulses. It takes 3-bit codes, the same encoding our 8-to-3 priority encoders produce, and drives the matching one-hot line. Each line is held high for a programmable number of cycles, followed by a programmable dead gap. It sits downstream of the encoder, turning a winning index back into a per-line strobe (select, grant or LED drive). One pending code is buffered while a pulse is in progress.

---
 rtl/seq_decoder_3to8_pkg.sv | 13 +
 rtl/seq_decoder_3to8_pend_buf.sv | 31 +++
 rtl/seq_decoder_3to8.sv | 125 ++++++++++++
 tb/tb_seq_decoder_3to8.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_decoder_3to8_pkg.sv
// Shared types and widths for the sequenced 3-to-8 decoder.
package seq_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } dec_state_t;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

endpackage

// File: rtl/seq_decoder_3to8_pend_buf.sv
// One-entry code buffer between the input handshake and the pulse sequencer.
module code_pend_buf
  import seq_dec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] code,
  output logic              full,
  output logic [CODE_W-1:0] data
);

  // A push always wins: a simultaneous pop empties the slot as it refills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data <= code;
    end
  end

endmodule

// File: rtl/seq_decoder_3to8.sv
// Registered 3-to-8 decoder: each accepted code becomes a timed one-hot pulse
// followed by an optional dead gap; one further code may wait in a buffer.
module seq_decoder_3to8
  import seq_dec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [OUT_W-1:0]  out_onehot,
  output logic              out_valid,
  output logic              busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam bit               HAS_GAP   = (GAP_CYCLES != 0);

  dec_state_t        state;
  dec_state_t        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [CODE_W-1:0] cur_code;
  logic [CODE_W-1:0] cur_next;
  logic [CODE_W-1:0] pend_code;
  logic [OUT_W-1:0]  out_next;
  logic              pend_full;
  logic              pend_full_next;
  logic              push;
  logic              pop;

  function automatic logic [OUT_W-1:0] decode(input logic [CODE_W-1:0] code);
    return OUT_W'(1) << code;
  endfunction

  assign in_ready       = !rst && en && (!pend_full || pop);
  assign push           = in_valid && in_ready;
  assign pend_full_next = push || (pend_full && !pop);

  code_pend_buf u_pend_buf (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .code (in_code),
    .full (pend_full),
    .data (pend_code)
  );

  // With en low everything holds and the output is blanked; HOLD re-drives
  // the current code on every counting cycle so it resumes cleanly.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cur_next   = cur_code;
    out_next   = '0;
    pop        = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          if (pend_full) begin
            pop        = 1'b1;
            cur_next   = pend_code;
            out_next   = decode(pend_code);
            cnt_next   = HOLD_LOAD;
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
            out_next = decode(cur_code);
          end else if (HAS_GAP) begin
            cnt_next   = GAP_LOAD;
            state_next = GAP;
          end else if (pend_full) begin
            pop      = 1'b1;
            cur_next = pend_code;
            out_next = decode(pend_code);
            cnt_next = HOLD_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
          end else begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      out_onehot <= out_next;
      out_valid  <= (out_next != '0);
      busy       <= (state_next != IDLE) || pend_full_next;
    end
  end

  always_ff @(posedge clk) begin
    cur_code <= cur_next;
  end

endmodule

// File: tb/tb_seq_decoder_3to8.sv
// Bench for seq_decoder_3to8: directed scenarios plus a randomized run
// against a schedule-based model, on a gapped and a gapless instance.
module tb_seq_decoder_3to8;

  localparam int H_CYC  = 4;
  localparam int G_A    = 1;
  localparam int G_B    = 0;
  localparam int N_RAND = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a, valid_a, ready_a, ovalid_a, busy_a;
  logic [2:0] code_a;
  logic [7:0] onehot_a;
  logic       en_b, valid_b, ready_b, ovalid_b, busy_b;
  logic [2:0] code_b;
  logic [7:0] onehot_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_out  [2][N_RAND+40];
  bit         exp_busy [2][N_RAND+40];

  always #5 clk = ~clk;

  seq_decoder_3to8 #(.HOLD_CYCLES(H_CYC), .GAP_CYCLES(G_A), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .in_valid(valid_a), .in_ready(ready_a),
    .in_code(code_a), .out_onehot(onehot_a), .out_valid(ovalid_a), .busy(busy_a)
  );

  seq_decoder_3to8 #(.HOLD_CYCLES(H_CYC), .GAP_CYCLES(G_B), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .in_valid(valid_b), .in_ready(ready_b),
    .in_code(code_b), .out_onehot(onehot_b), .out_valid(ovalid_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en_a = 1'b1; en_b = 1'b1;
    valid_a = 1'b1; code_a = 3'd1;
    valid_b = 1'b0; code_b = 3'd0;
    rst = 1'b1;
    #1;
    total++;
    if (ready_a !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b want=0", ready_a);
    end
    tick();
    valid_a = 1'b0;
    total++;
    if (onehot_a !== 8'h00 || ovalid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got=%h/%b/%b want=00/0/0", onehot_a, ovalid_a, busy_a);
    end
    rst = 1'b0;
    #1;
    total++;
    if (ready_a !== 1'b1) begin
      bad++; $display("FAIL ready_after_release got=%b want=1", ready_a);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (onehot_a !== 8'h00) begin
        bad++; $display("FAIL reset_accept_dropped k=%0d got=%h want=00", k, onehot_a);
      end
    end
    valid_a = 1'b1; code_a = 3'd5;
    tick();
    valid_a = 1'b0;
    tick();
    tick();
    total++;
    if (onehot_a !== 8'h20) begin
      bad++; $display("FAIL pre_reset_pulse got=%h want=20", onehot_a);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (onehot_a !== 8'h00 || ovalid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL reset_mid_pulse got=%h/%b/%b want=00/0/0", onehot_a, ovalid_a, busy_a);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (onehot_a !== 8'h00) begin
        bad++; $display("FAIL no_resume k=%0d got=%h want=00", k, onehot_a);
      end
    end
    total++;
    if (ready_a !== 1'b1) begin
      bad++; $display("FAIL ready_post_reset got=%b want=1", ready_a);
    end
  endtask

  task automatic test_single_code();
    logic [7:0] want;
    valid_a = 1'b1; code_a = 3'd5;
    #1;
    total++;
    if (ready_a !== 1'b1) begin
      bad++; $display("FAIL single_ready_pre got=%b want=1", ready_a);
    end
    tick();
    valid_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      want = (k >= 1 && k <= H_CYC) ? 8'h20 : 8'h00;
      total++;
      if (onehot_a !== want || ovalid_a !== (want != 0)) begin
        bad++; $display("FAIL single_pulse edge=%0d got=%h/%b want=%h/%b", k, onehot_a, ovalid_a, want, want != 0);
      end
      total++;
      if (ready_a !== 1'b1) begin
        bad++; $display("FAIL single_ready edge=%0d got=%b want=1", k, ready_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    logic       want_rdy;
    valid_a = 1'b1; code_a = 3'd3;
    tick();
    code_a = 3'd6;
    total++;
    if (ready_a !== 1'b1) begin
      bad++; $display("FAIL b2b_ready_second got=%b want=1", ready_a);
    end
    tick();
    valid_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) tick();
      want     = (k <= 4) ? 8'h08 : (k >= 7 && k <= 10) ? 8'h40 : 8'h00;
      want_rdy = !(k >= 1 && k <= 5);
      total++;
      if (onehot_a !== want) begin
        bad++; $display("FAIL b2b_pulse edge=%0d got=%h want=%h", k, onehot_a, want);
      end
      total++;
      if (ready_a !== want_rdy) begin
        bad++; $display("FAIL b2b_ready edge=%0d got=%b want=%b", k, ready_a, want_rdy);
      end
    end
  endtask

  task automatic test_no_gap();
    logic [7:0] want;
    valid_b = 1'b1; code_b = 3'd0;
    tick();
    code_b = 3'd7;
    tick();
    valid_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) tick();
      want = (k <= 4) ? 8'h01 : (k <= 8) ? 8'h80 : 8'h00;
      total++;
      if (onehot_b !== want || ovalid_b !== (want != 0)) begin
        bad++; $display("FAIL nogap_pulse edge=%0d got=%h/%b want=%h/%b", k, onehot_b, ovalid_b, want, want != 0);
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic [7:0] want;
    int         hi = 0;
    valid_a = 1'b1; code_a = 3'd2;
    tick();
    valid_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      want = (k == 1 || k == 2 || k == 6 || k == 7) ? 8'h04 : 8'h00;
      if (onehot_a == 8'h04) hi++;
      total++;
      if (onehot_a !== want) begin
        bad++; $display("FAIL freeze_pulse edge=%0d got=%h want=%h", k, onehot_a, want);
      end
      if (k == 2) en_a = 1'b0;
      if (k == 5) en_a = 1'b1;
      #1;
      total++;
      if (ready_a !== en_a) begin
        bad++; $display("FAIL freeze_ready edge=%0d got=%b want=%b", k, ready_a, en_a);
      end
    end
    total++;
    if (hi != H_CYC) begin
      bad++; $display("FAIL freeze_high_count got=%0d want=%0d", hi, H_CYC);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] want;
    for (int c = 0; c < 8; c++) begin
      valid_a = 1'b1; code_a = 3'(c);
      tick();
      valid_a = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        tick();
        want = (k <= H_CYC) ? (8'h01 << c) : 8'h00;
        total++;
        if (onehot_a !== want || !$onehot0(onehot_a)) begin
          bad++; $display("FAIL sweep code=%0d edge=%0d got=%h want=%h", c, k, onehot_a, want);
        end
      end
    end
  endtask

  task automatic test_random();
    int         next_free [2];
    int         last_s    [2];
    int         gap       [2];
    bit         v         [2];
    bit         rdy_exp   [2];
    logic [2:0] c         [2];
    logic [7:0] got_oh;
    logic       got_ov, got_busy, got_rdy;
    int         s;
    gap[0] = G_A; gap[1] = G_B;
    for (int d = 0; d < 2; d++) begin
      next_free[d] = 0;
      last_s[d]    = -1;
      for (int t = 0; t < N_RAND + 40; t++) begin
        exp_out[d][t]  = 8'h00;
        exp_busy[d][t] = 1'b0;
      end
    end
    en_a = 1'b1; en_b = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= N_RAND; e++) begin
      for (int d = 0; d < 2; d++) begin
        v[d]       = ($urandom_range(0, 1) == 1);
        c[d]       = 3'($urandom_range(0, 7));
        rdy_exp[d] = !(last_s[d] > e);
      end
      valid_a = v[0]; code_a = c[0];
      valid_b = v[1]; code_b = c[1];
      #1;
      for (int d = 0; d < 2; d++) begin
        got_rdy = (d == 0) ? ready_a : ready_b;
        total++;
        if (got_rdy !== rdy_exp[d]) begin
          bad++; $display("FAIL rand_ready dut=%0d edge=%0d got=%b want=%b", d, e, got_rdy, rdy_exp[d]);
        end
        if (v[d] && rdy_exp[d]) begin
          s = (e + 1 > next_free[d]) ? e + 1 : next_free[d];
          for (int t = s; t < s + H_CYC; t++) exp_out[d][t] = 8'h01 << c[d];
          for (int t = e; t < s + H_CYC + gap[d]; t++) exp_busy[d][t] = 1'b1;
          next_free[d] = s + H_CYC + ((gap[d] > 0) ? gap[d] + 1 : 0);
          last_s[d]    = s;
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        got_oh   = (d == 0) ? onehot_a : onehot_b;
        got_ov   = (d == 0) ? ovalid_a : ovalid_b;
        got_busy = (d == 0) ? busy_a : busy_b;
        total++;
        if (got_oh !== exp_out[d][e] || !$onehot0(got_oh)) begin
          bad++; $display("FAIL rand_onehot dut=%0d edge=%0d got=%h want=%h", d, e, got_oh, exp_out[d][e]);
        end
        total++;
        if (got_ov !== (exp_out[d][e] != 8'h00)) begin
          bad++; $display("FAIL rand_valid dut=%0d edge=%0d got=%b want=%b", d, e, got_ov, exp_out[d][e] != 8'h00);
        end
        total++;
        if (got_busy !== exp_busy[d][e]) begin
          bad++; $display("FAIL rand_busy dut=%0d edge=%0d got=%b want=%b", d, e, got_busy, exp_busy[d][e]);
        end
      end
    end
    valid_a = 1'b0; valid_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_code();
    test_back_to_back();
    test_no_gap();
    test_enable_freeze();
    test_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
